// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V control path: states, opcodes, mux selects.
// Optional feature macro: RV_JAL_EN (adds the JAL state and opcode decode).
package multicycle_control_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_TRAP     = 4'd10;
`ifdef RV_JAL_EN
    localparam logic [3:0] S_JAL      = 4'd11;
`endif

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // State that follows DECODE for a given opcode.
    function automatic logic [3:0] decode_next(input logic [6:0] op);
        logic [3:0] nxt;
        nxt = S_TRAP;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXECR;
            OP_ITYPE:     nxt = S_EXECI;
            OP_BEQ:       nxt = S_BEQ;
`ifdef RV_JAL_EN
            OP_JAL:       nxt = S_JAL;
`else
            OP_JAL:       nxt = S_TRAP;
`endif
            default:      nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_ctrl_decode.sv
// Moore output decode: a pure function of the current state to the datapath controls.
// Optional feature macro: RV_JAL_EN (drives the JAL state's controls).
import multicycle_control_pkg::*;

module ctrl_decode #(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] i_state,
    output logic               o_pc_update,
    output logic               o_branch,
    output logic               o_adr_src,
    output logic               o_mem_write,
    output logic               o_ir_write,
    output logic               o_reg_write,
    output logic [1:0]         o_result_src,
    output logic [1:0]         o_alu_src_a,
    output logic [1:0]         o_alu_src_b,
    output logic [1:0]         o_alu_op
);

    always_comb begin
        o_pc_update  = 1'b0;
        o_branch     = 1'b0;
        o_adr_src    = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RS2;
        o_alu_op     = ALUOP_ADD;
        case (i_state)
            // Fetch enables are qualified by mem_ready in the top level.
            STATE_W'(S_FETCH): begin
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALU;
                o_ir_write   = 1'b1;
                o_pc_update  = 1'b1;
            end
            STATE_W'(S_DECODE): begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
            end
            STATE_W'(S_MEMADR): begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
            end
            STATE_W'(S_MEMREAD): o_adr_src = 1'b1;
            STATE_W'(S_MEMWB): begin
                o_result_src = RES_DATA;
                o_reg_write  = 1'b1;
            end
            STATE_W'(S_MEMWRITE): begin
                o_adr_src   = 1'b1;
                o_mem_write = 1'b1;
            end
            STATE_W'(S_EXECR): begin
                o_alu_src_a = SRCA_RS1;
                o_alu_op    = ALUOP_FUNCT;
            end
            STATE_W'(S_EXECI): begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = ALUOP_FUNCT;
            end
            STATE_W'(S_ALUWB): o_reg_write = 1'b1;
            STATE_W'(S_BEQ): begin
                o_alu_src_a = SRCA_RS1;
                o_alu_op    = ALUOP_SUB;
                o_branch    = 1'b1;
            end
`ifdef RV_JAL_EN
            // PC takes the DECODE-computed target from ALUOut; ALU forms old PC + 4 for rd.
            STATE_W'(S_JAL): begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_FOUR;
                o_pc_update = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: state register, next-state logic, sticky illegal flag.
// Optional feature macro: RV_JAL_EN (routes op 1101111 through a JAL state).
import multicycle_control_pkg::*;

module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_dec_state;
    logic               r_illegal;
    logic               w_pc_update;
    logic               w_branch;
    logic               w_ir_write;
    logic               w_fetch_hold;

    // Reset presents FETCH to the decoder so the mux selects already point at fetch.
    assign w_dec_state  = rst ? STATE_W'(S_FETCH) : r_state;
    assign w_fetch_hold = rst | ((r_state == STATE_W'(S_FETCH)) & ~mem_ready);

    ctrl_decode #(.STATE_W(STATE_W)) u_dec (
        .i_state      (w_dec_state),
        .o_pc_update  (w_pc_update),
        .o_branch     (w_branch),
        .o_adr_src    (adr_src),
        .o_mem_write  (mem_write),
        .o_ir_write   (w_ir_write),
        .o_reg_write  (reg_write),
        .o_result_src (result_src),
        .o_alu_src_a  (alu_src_a),
        .o_alu_src_b  (alu_src_b),
        .o_alu_op     (alu_op)
    );

    assign ir_write = w_ir_write & ~w_fetch_hold;
    assign pc_write = (w_pc_update & ~w_fetch_hold) | (w_branch & zero);
    assign illegal  = r_illegal & ~rst;

    always_comb begin
        w_next = STATE_W'(S_FETCH);
        case (r_state)
            STATE_W'(S_FETCH):    w_next = mem_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            STATE_W'(S_DECODE):   w_next = STATE_W'(decode_next(op));
            STATE_W'(S_MEMADR):   w_next = (op == OP_LW) ? STATE_W'(S_MEMREAD) : STATE_W'(S_MEMWRITE);
            STATE_W'(S_MEMREAD):  w_next = mem_ready ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMREAD);
            STATE_W'(S_MEMWB):    w_next = STATE_W'(S_FETCH);
            STATE_W'(S_MEMWRITE): w_next = mem_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWRITE);
            STATE_W'(S_EXECR):    w_next = STATE_W'(S_ALUWB);
            STATE_W'(S_EXECI):    w_next = STATE_W'(S_ALUWB);
            STATE_W'(S_ALUWB):    w_next = STATE_W'(S_FETCH);
            STATE_W'(S_BEQ):      w_next = STATE_W'(S_FETCH);
            STATE_W'(S_TRAP):     w_next = STATE_W'(S_TRAP);
`ifdef RV_JAL_EN
            STATE_W'(S_JAL):      w_next = STATE_W'(S_ALUWB);
`endif
            default:              w_next = STATE_W'(S_FETCH);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= STATE_W'(S_FETCH);
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == STATE_W'(S_TRAP))
                r_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; checks the packed output word each cycle.
// Build with RV_JAL_EN defined to exercise the JAL path.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [6:0] op;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .illegal(illegal)
    );

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal}
    logic [13:0] outv;
    assign outv = {pc_write, adr_src, mem_write, ir_write, result_src,
                   alu_src_a, alu_src_b, alu_op, reg_write, illegal};

    localparam logic [13:0] F1   = 14'b1_0_0_1_10_00_10_00_0_0;
    localparam logic [13:0] F0   = 14'b0_0_0_0_10_00_10_00_0_0;
    localparam logic [13:0] DEC  = 14'b0_0_0_0_00_01_01_00_0_0;
    localparam logic [13:0] MA   = 14'b0_0_0_0_00_10_01_00_0_0;
    localparam logic [13:0] MR   = 14'b0_1_0_0_00_00_00_00_0_0;
    localparam logic [13:0] MWB  = 14'b0_0_0_0_01_00_00_00_1_0;
    localparam logic [13:0] MW   = 14'b0_1_1_0_00_00_00_00_0_0;
    localparam logic [13:0] EXR  = 14'b0_0_0_0_00_10_00_10_0_0;
    localparam logic [13:0] EXI  = 14'b0_0_0_0_00_10_01_10_0_0;
    localparam logic [13:0] AWB  = 14'b0_0_0_0_00_00_00_00_1_0;
    localparam logic [13:0] BQ1  = 14'b1_0_0_0_00_10_00_01_0_0;
    localparam logic [13:0] BQ0  = 14'b0_0_0_0_00_10_00_01_0_0;
    localparam logic [13:0] TRP  = 14'b0_0_0_0_00_00_00_00_0_1;
    localparam logic [13:0] JALV = 14'b1_0_0_0_00_01_10_00_0_0;

    task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Settle, compare the current-cycle outputs, then advance to the next negedge.
    task automatic cyc(input string tag, input logic [13:0] exp);
        #1;
        chk(tag, outv, exp);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; op = 7'b0000011; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc("rst_idle", F0);
        mem_ready = 1'b1;
        cyc("rst_mr1", F0);

        // lw, no stalls: 5 cycles
        rst = 1'b0; op = 7'b0000011;
        cyc("lw_fetch", F1); cyc("lw_dec", DEC); cyc("lw_madr", MA);
        cyc("lw_mrd", MR);
        mem_ready = 1'b0;
        cyc("lw_wb", MWB); cyc("lw_back", F0);

        // sw with 3 stall cycles in MEMWRITE
        mem_ready = 1'b1; op = 7'b0100011;
        cyc("sw_fetch", F1); cyc("sw_dec", DEC); cyc("sw_madr", MA);
        mem_ready = 1'b0;
        cyc("sw_wr0", MW); cyc("sw_wr1", MW); cyc("sw_wr2", MW);
        mem_ready = 1'b1;
        cyc("sw_wr3", MW);
        mem_ready = 1'b0;
        cyc("sw_back", F0);

        // R-type and I-type
        mem_ready = 1'b1; op = 7'b0110011;
        cyc("r_fetch", F1); cyc("r_dec", DEC); cyc("r_exec", EXR);
        mem_ready = 1'b0;
        cyc("r_wb", AWB); cyc("r_back", F0);
        mem_ready = 1'b1; op = 7'b0010011;
        cyc("i_fetch", F1); cyc("i_dec", DEC); cyc("i_exec", EXI);
        mem_ready = 1'b0;
        cyc("i_wb", AWB); cyc("i_back", F0);

        // beq taken / not taken
        mem_ready = 1'b1; op = 7'b1100011; zero = 1'b1;
        cyc("beqt_fetch", F1); cyc("beqt_dec", DEC);
        mem_ready = 1'b0;
        cyc("beqt_br", BQ1); cyc("beqt_back", F0);
        mem_ready = 1'b1; zero = 1'b0;
        cyc("beqn_fetch", F1); cyc("beqn_dec", DEC);
        mem_ready = 1'b0;
        cyc("beqn_br", BQ0); cyc("beqn_back", F0);

        // lw with memory stalls in MEMREAD
        mem_ready = 1'b1; op = 7'b0000011;
        cyc("lws_fetch", F1); cyc("lws_dec", DEC); cyc("lws_madr", MA);
        mem_ready = 1'b0;
        cyc("lws_mr0", MR); cyc("lws_mr1", MR);
        mem_ready = 1'b1;
        cyc("lws_mr2", MR);
        mem_ready = 1'b0;
        cyc("lws_wb", MWB); cyc("lws_back", F0);

        // reset in MEMREAD: no writeback follows
        mem_ready = 1'b1;
        cyc("lwr_fetch", F1); cyc("lwr_dec", DEC); cyc("lwr_madr", MA);
        mem_ready = 1'b0;
        cyc("lwr_mr", MR);
        rst = 1'b1;
        cyc("lwr_rst", F0);
        rst = 1'b0;
        cyc("lwr_after", F0);
        cyc("lwr_after2", F0);

        // illegal opcode traps and sticks until reset
        mem_ready = 1'b1; op = 7'b0000000;
        cyc("trap_fetch", F1); cyc("trap_dec", DEC);
        for (int i = 0; i < 10; i++) cyc($sformatf("trap_hold%0d", i), TRP);
        zero = 1'b1;
        cyc("trap_zero", TRP);
        zero = 1'b0; rst = 1'b1; mem_ready = 1'b0;
        cyc("trap_rst", F0);
        rst = 1'b0;
        cyc("trap_clear", F0);

        // jal
        mem_ready = 1'b1; op = 7'b1101111;
        cyc("jal_fetch", F1); cyc("jal_dec", DEC);
        mem_ready = 1'b0;
`ifdef RV_JAL_EN
        cyc("jal_jal", JALV); cyc("jal_wb", AWB); cyc("jal_back", F0);
`else
        cyc("jal_trap", TRP); cyc("jal_trap2", TRP);
        rst = 1'b1;
        cyc("jal_rst", F0);
        rst = 1'b0;
        cyc("jal_clear", F0);
`endif

        // another unsupported opcode (SYSTEM) also traps
        mem_ready = 1'b1; op = 7'b1110011;
        cyc("sys_fetch", F1); cyc("sys_dec", DEC);
        cyc("sys_trap", TRP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
